// File: rtl/load_store_unit_if.sv
// Core-request and memory-bus signals of the load/store unit, bundled with
// the unit's (slave) and environment's (master) views.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, instruction, addr, store_data, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_fault,
           mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, instruction, addr, store_data, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_fault,
           mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store unit: decodes the access, drives one word-aligned
// memory transaction with lane-replicated store data, and returns an extended load result.
module load_store_unit (
  input  logic             clk,
  input  logic             reset_n,
  load_store_unit_if.slave bus
);

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, legal, misaligned, fault;
  logic [3:0]  store_wstrb;
  logic [31:0] store_wdata;
  logic [31:0] rdata_shift;
  logic [31:0] load_data;
  logic        unused_instr;

  assign opcode   = bus.instruction[6:0];
  assign funct3   = bus.instruction[14:12];
  assign is_load  = (opcode == OpcLoad);
  assign is_store = (opcode == OpcStore);

  assign legal = (is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                 (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));

  // funct3[1:0] encodes access size for every legal load and store.
  assign misaligned = ((funct3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
  assign fault      = !legal || misaligned;

  assign unused_instr = ^{bus.instruction[31:15], bus.instruction[11:7]};

  always_comb begin
    store_wstrb = 4'b1111;
    store_wdata = bus.store_data;
    unique case (funct3[1:0])
      2'b00: begin
        store_wstrb = 4'b0001 << bus.addr[1:0];
        store_wdata = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        store_wstrb = bus.addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend; funct3[2] marks unsigned.
  always_comb begin
    rdata_shift = bus.mem_rdata >> {addr_lo_q, 3'b000};
    unique case (funct3_q[1:0])
      2'b00:   load_data = {{24{~funct3_q[2] & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_data = {{16{~funct3_q[2] & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'h0;
    resp_fault_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          funct3_d  = funct3;
          addr_lo_d = bus.addr[1:0];
          if (fault) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d     = StMem;
            mem_valid_d = 1'b1;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_we_d    = is_store;
            mem_wstrb_d = is_store ? store_wstrb : 4'b0000;
            mem_wdata_d = is_store ? store_wdata : 32'h0;
          end
        end
      end
      StMem: begin
        if (bus.mem_ready) begin
          state_d      = StResp;
          mem_valid_d  = 1'b0;
          mem_addr_d   = 32'h0;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = 4'b0000;
          mem_wdata_d  = 32'h0;
          resp_valid_d = 1'b1;
          resp_data_d  = mem_we_q ? 32'h0 : load_data;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each task drives one scenario and checks
// the outputs against hand-computed values one time unit after the rising edge.
module tb_load_store_unit;

  localparam logic [6:0] Load  = 7'b0000011;
  localparam logic [6:0] Store = 7'b0100011;

  // Mixed store/load vectors with zero-wait memory.
  localparam logic        VST   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [2:0]  VF3   [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd1, 3'd1, 3'd2, 3'd0};
  localparam logic [31:0] VADDR [9] = '{32'h5001, 32'h5003, 32'h5000, 32'h5004, 32'h6002,
                                        32'h6002, 32'h6000, 32'h6008, 32'h6001};
  localparam logic [31:0] VSD   [9] = '{32'h123456A7, 32'h000000FF, 32'h89AB1234, 32'hDEADBEEF,
                                        32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] VRD   [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11F23344,
                                        32'h80017FFF, 32'h80017FFF, 32'h89ABCDEF, 32'h00007F00};
  localparam logic [3:0]  VSTRB [9] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111,
                                        4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  localparam logic [31:0] VWD   [9] = '{32'hA7A7A7A7, 32'hFFFFFFFF, 32'h12341234, 32'hDEADBEEF,
                                        32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] VRESP [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h000000F2,
                                        32'hFFFF8001, 32'h00007FFF, 32'h89ABCDEF, 32'h0000007F};

  logic clk;
  logic reset_n;
  int   checks;
  int   passed;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    mk = {17'h0, f3, 5'h0, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request while idle; returns in the first cycle after acceptance
  // with the request inputs scrambled to prove they were captured.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] d);
    bus.instruction = instr;
    bus.addr        = a;
    bus.store_data  = d;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid   = 1'b0;
    bus.instruction = 32'hFFFF_FFFF;
    bus.addr        = 32'h5555_5555;
    bus.store_data  = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.resp_valid, bus.resp_fault}
        !== 9'b1_0_0_0000_0_0)
      $display("FAIL reset_ctrl: got %b want 100000000", {bus.req_ready, bus.mem_valid,
               bus.mem_we, bus.mem_wstrb, bus.resp_valid, bus.resp_fault});
    else passed++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.resp_data} !== 96'h0)
      $display("FAIL reset_data: got %h %h %h want 0 0 0", bus.mem_addr, bus.mem_wdata,
               bus.resp_data);
    else passed++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_lb_zero_wait();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h80123456;
    issue(mk(Load, 3'b000), 32'h1003, 32'h0);
    checks++;
    if ({bus.mem_valid, bus.req_ready, bus.mem_we, bus.mem_wstrb, bus.resp_valid} !== 8'b1_0_0_0000_0)
      $display("FAIL lb_mem_ctrl: got %b want 10000000", {bus.mem_valid, bus.req_ready,
               bus.mem_we, bus.mem_wstrb, bus.resp_valid});
    else passed++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {32'h1000, 32'h0})
      $display("FAIL lb_mem_addr: got %h/%h want 00001000/00000000", bus.mem_addr, bus.mem_wdata);
    else passed++;
    tick();
    checks++;
    if ({bus.resp_valid, bus.resp_fault, bus.resp_data, bus.mem_valid} !== {2'b10, 32'hFFFFFF80, 1'b0})
      $display("FAIL lb_resp: got v=%b f=%b d=%h mv=%b want v=1 f=0 d=ffffff80 mv=0",
               bus.resp_valid, bus.resp_fault, bus.resp_data, bus.mem_valid);
    else passed++;
    bus.mem_ready = 1'b0;
    tick();
    checks++;
    if ({bus.resp_valid, bus.req_ready, bus.resp_data} !== {2'b01, 32'h0})
      $display("FAIL lb_resp_end: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", bus.resp_valid,
               bus.req_ready, bus.resp_data);
    else passed++;
  endtask

  task automatic test_sh_wait();
    bus.mem_ready = 1'b0;
    issue(mk(Store, 3'b001), 32'h2002, 32'hCAFEBEEF);
    checks++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr}
        !== {2'b11, 4'b1100, 32'hBEEFBEEF, 32'h2000})
      $display("FAIL sh_mem: got v=%b we=%b s=%b wd=%h a=%h want 1 1 1100 beefbeef 00002000",
               bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr);
    else passed++;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.resp_valid, bus.resp_fault, bus.resp_data} !== {2'b10, 32'h0})
      $display("FAIL sh_resp: got v=%b f=%b d=%h want 1 0 0", bus.resp_valid, bus.resp_fault,
               bus.resp_data);
    else passed++;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] instrs [3];
    logic [31:0] addrs  [3];
    instrs[0] = mk(Load, 3'b010);        addrs[0] = 32'h3001;
    instrs[1] = mk(7'b0110011, 3'b000);  addrs[1] = 32'h3000;
    instrs[2] = mk(Load, 3'b011);        addrs[2] = 32'h3000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(instrs[i], addrs[i], 32'h12345678);
      checks++;
      if ({bus.mem_valid, bus.resp_valid, bus.resp_fault, bus.resp_data} !== {3'b011, 32'h0})
        $display("FAIL fault_%0d_resp: got mv=%b v=%b f=%b d=%h want 0 1 1 0", i, bus.mem_valid,
                 bus.resp_valid, bus.resp_fault, bus.resp_data);
      else passed++;
      tick();
      checks++;
      if ({bus.mem_valid, bus.resp_valid, bus.resp_fault, bus.req_ready} !== 4'b0001)
        $display("FAIL fault_%0d_after: got mv=%b v=%b f=%b rdy=%b want 0 0 0 1", i,
                 bus.mem_valid, bus.resp_valid, bus.resp_fault, bus.req_ready);
      else passed++;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_lhu_stall();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hABCD0000;
    issue(mk(Load, 3'b101), 32'h4002, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.mem_valid, bus.req_ready, bus.resp_valid, bus.mem_we, bus.mem_wstrb, bus.mem_addr,
           bus.mem_wdata} !== {8'b1_0_0_0_0000, 32'h4000, 32'h0})
        $display("FAIL lhu_stall_%0d: got v=%b rdy=%b rv=%b a=%h want 1 0 0 00004000", i,
                 bus.mem_valid, bus.req_ready, bus.resp_valid, bus.mem_addr);
      else passed++;
      tick();
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.resp_valid, bus.resp_fault, bus.resp_data} !== {2'b10, 32'h0000ABCD})
      $display("FAIL lhu_resp: got v=%b f=%b d=%h want 1 0 0000abcd", bus.resp_valid,
               bus.resp_fault, bus.resp_data);
    else passed++;
    tick();
  endtask

  task automatic test_lanes();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.mem_rdata = VRD[i];
      issue(mk(VST[i] ? Store : Load, VF3[i]), VADDR[i], VSD[i]);
      checks++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr}
          !== {1'b1, VST[i], VSTRB[i], VWD[i], VADDR[i] & 32'hFFFF_FFFC})
        $display("FAIL lane_%0d_mem: got we=%b s=%b wd=%h a=%h want %b %b %h %h", i, bus.mem_we,
                 bus.mem_wstrb, bus.mem_wdata, bus.mem_addr, VST[i], VSTRB[i], VWD[i],
                 VADDR[i] & 32'hFFFF_FFFC);
      else passed++;
      tick();
      checks++;
      if ({bus.resp_valid, bus.resp_fault, bus.resp_data} !== {2'b10, VRESP[i]})
        $display("FAIL lane_%0d_resp: got v=%b f=%b d=%h want 1 0 %h", i, bus.resp_valid,
                 bus.resp_fault, bus.resp_data, VRESP[i]);
      else passed++;
      tick();
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.mem_ready   = 1'b1;
    bus.mem_rdata   = 32'h11111111;
    bus.instruction = mk(Load, 3'b010);
    bus.addr        = 32'h7000;
    bus.req_valid   = 1'b1;
    tick();
    bus.addr = 32'h7004;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_addr} !== {2'b01, 32'h7000})
      $display("FAIL b2b_first: got rdy=%b mv=%b a=%h want 0 1 00007000", bus.req_ready,
               bus.mem_valid, bus.mem_addr);
    else passed++;
    tick();
    checks++;
    if ({bus.resp_valid, bus.req_ready, bus.mem_valid, bus.resp_data} !== {3'b100, 32'h11111111})
      $display("FAIL b2b_resp1: got v=%b rdy=%b mv=%b d=%h want 1 0 0 11111111", bus.resp_valid,
               bus.req_ready, bus.mem_valid, bus.resp_data);
    else passed++;
    tick();
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.resp_valid} !== 3'b100)
      $display("FAIL b2b_gap: got rdy=%b mv=%b v=%b want 1 0 0", bus.req_ready, bus.mem_valid,
               bus.resp_valid);
    else passed++;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_rdata = 32'h22222222;
    checks++;
    if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h7004})
      $display("FAIL b2b_second: got mv=%b a=%h want 1 00007004", bus.mem_valid, bus.mem_addr);
    else passed++;
    tick();
    checks++;
    if ({bus.resp_valid, bus.resp_data} !== {1'b1, 32'h22222222})
      $display("FAIL b2b_resp2: got v=%b d=%h want 1 22222222", bus.resp_valid, bus.resp_data);
    else passed++;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_mem();
    bus.mem_ready = 1'b0;
    issue(mk(Load, 3'b010), 32'h8000, 32'h0);
    checks++;
    if (bus.mem_valid !== 1'b1)
      $display("FAIL rst_mem_pre: got mv=%b want 1", bus.mem_valid);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_valid, bus.req_ready, bus.resp_valid, bus.mem_addr} !== {3'b010, 32'h0})
      $display("FAIL rst_mem_async: got mv=%b rdy=%b v=%b a=%h want 0 1 0 0", bus.mem_valid,
               bus.req_ready, bus.resp_valid, bus.mem_addr);
    else passed++;
    bus.mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.resp_valid, bus.mem_valid, bus.req_ready} !== 3'b001)
        $display("FAIL rst_mem_after_%0d: got v=%b mv=%b rdy=%b want 0 0 1", i, bus.resp_valid,
                 bus.mem_valid, bus.req_ready);
      else passed++;
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    clk             = 1'b0;
    checks          = 0;
    passed          = 0;
    bus.req_valid   = 1'b0;
    bus.instruction = 32'h0;
    bus.addr        = 32'h0;
    bus.store_data  = 32'h0;
    bus.mem_ready   = 1'b0;
    bus.mem_rdata   = 32'h0;
    test_reset();
    test_lb_zero_wait();
    test_sh_wait();
    test_faults();
    test_lhu_stall();
    test_lanes();
    test_back_to_back();
    test_reset_in_mem();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
